// File: rtl/switch_debounce.sv
// ============================================================================
// switch_debounce : N-channel switch synchronizer/debouncer with edge pulses
// Revision 1.0
// ============================================================================
`default_nettype none

module switch_debounce #(
  parameter int N             = 6,
  parameter int STABLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sw_in,
  output logic [N-1:0] sw_level,
  output logic [N-1:0] sw_rise,
  output logic [N-1:0] sw_fall,
  output logic [N-1:0] sw_toggle
);

  localparam int                CNT_W   = ($clog2(STABLE_CYCLES) > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [N-1:0]     sync1;
  logic [N-1:0]     sync2;
  logic [CNT_W-1:0] cnt [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      sw_level  <= '0;
      sw_rise   <= '0;
      sw_fall   <= '0;
      sw_toggle <= '0;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
      for (int i = 0; i < N; i++) begin
        sw_rise[i] <= 1'b0;
        sw_fall[i] <= 1'b0;
        if (sync2[i] == sw_level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          // Candidate level held long enough: commit it and flag the edge.
          cnt[i]      <= '0;
          sw_level[i] <= sync2[i];
          if (sync2[i]) begin
            sw_rise[i]   <= 1'b1;
            sw_toggle[i] <= ~sw_toggle[i];
          end else begin
            sw_fall[i] <= 1'b1;
          end
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire
